// File: rtl/fetch_pkg.sv
// Shared widths and the queue entry payload for the prefetching fetch unit.
package fetch_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = XLEN / 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // One queued instruction tagged with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is read combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = fetch_pkg::DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = $clog2(DEPTH) + 1;

    fetch_entry_t          mem [DEPTH];
    logic [PTR_BITS-1:0]   head_ptr;
    logic [PTR_BITS-1:0]   tail_ptr;
    logic                  do_push;
    logic                  do_pop;

    // Qualify push/pop against reset, flush and an empty queue.
    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (!rst && !flush) begin
            do_push = push;
            do_pop  = pop && (count != '0);
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) tail_ptr <= tail_ptr + PTR_BITS'(1);
            if (do_pop)  head_ptr <= head_ptr + PTR_BITS'(1);
            if (do_push && !do_pop)      count <= count + CNT_BITS'(1);
            else if (!do_push && do_pop) count <= count - CNT_BITS'(1);
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail_ptr] <= push_data;
    end

    assign head = mem[head_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Prefetching fetch stage: issues sequential imem reads, queues tagged responses
// for decode, and restarts on redirect with the in-flight response discarded.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     DEPTH    = fetch_pkg::DEPTH,
    parameter int unsigned     PC_STEP  = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   imem_req_valid,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [ILEN-1:0]        imem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [ILEN-1:0]        out_instr,
    output logic [$clog2(DEPTH):0] queue_count
);

    localparam int unsigned CNT_BITS = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]     fetch_pc;
    logic [XLEN-1:0]     tag;
    logic                inflight;
    logic                issue_c;
    logic                push_c;
    logic                pop_c;
    logic [CNT_BITS-1:0] count;
    fetch_entry_t        head;
    fetch_entry_t        push_data;

    // Credit check: queued plus in-flight must leave room for the new response.
    always_comb begin
        issue_c = 1'b0;
        if (!rst && !redirect_valid &&
            ((count + CNT_BITS'(inflight)) < CNT_BITS'(DEPTH))) begin
            issue_c = 1'b1;
        end
    end

    // A redirect kills the response arriving this cycle and ignores any pop.
    always_comb begin
        push_c          = inflight && !redirect_valid;
        pop_c           = out_valid && out_ready && !redirect_valid;
        push_data.pc    = tag;
        push_data.instr = imem_rdata;
    end

    // Fetch PC, in-flight flag and PC tag for the outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            tag      <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue_c;
            if (issue_c) begin
                fetch_pc <= fetch_pc + XLEN'(PC_STEP);
                tag      <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push_c),
        .push_data (push_data),
        .pop       (pop_c),
        .head      (head),
        .count     (count)
    );

    assign imem_req_valid = issue_c;
    assign imem_addr      = fetch_pc;
    assign out_valid      = (count != '0);
    assign out_pc         = out_valid ? head.pc    : '0;
    assign out_instr      = out_valid ? head.instr : '0;
    assign queue_count    = count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit; memory returns the address as data.
module tb_fetch_queue_unit;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_rdata = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;
    logic [2:0]      queue_count;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] sb [$];
    logic [XLEN-1:0] exp;

    fetch_queue_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .queue_count    (queue_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data is the low bits of the address, one cycle later.
    always @(posedge clk)
        imem_rdata <= imem_req_valid ? ILEN'(imem_addr) : 32'hDEAD_BEEF;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; out_ready = rdy;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req_valid); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", queue_count); end
        checks++; if (out_pc !== '0) begin errors++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
        checks++; if (out_instr !== '0) begin errors++; $display("FAIL reset_instr: got %h expected 0", out_instr); end
    endtask

    task automatic test_steady;
        do_reset(1'b1);
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'd0) begin errors++; $display("FAIL first_req: got valid=%b addr=%h expected 1/0", imem_req_valid, imem_addr); end
        sb.delete();
        for (int k = 0; k < 10; k++) sb.push_back(64'(k));
        for (int i = 0; i < 12; i++) begin
            if (i == 1) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL steady_latency: got out_valid=%b expected 0", out_valid); end
            end
            if (i >= 2) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL steady_gap: cycle %0d got out_valid=%b expected 1", i, out_valid); end
            end
            if (out_valid === 1'b1 && sb.size() != 0) begin
                exp = sb.pop_front();
                checks++; if (out_pc !== exp || out_instr !== ILEN'(exp)) begin errors++; $display("FAIL steady_seq: got pc=%h instr=%h expected pc=%h", out_pc, out_instr, exp); end
            end
            @(negedge clk); #1;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL steady_drain: %0d entries left expected 0", sb.size()); end
    endtask

    task automatic test_stall;
        do_reset(1'b0);
        repeat (10) @(negedge clk);
        #1;
        checks++; if (queue_count !== 3'd4) begin errors++; $display("FAIL stall_count: got %0d expected 4", queue_count); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req: got %b expected 0", imem_req_valid); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'd0) begin errors++; $display("FAIL stall_head: got valid=%b pc=%h expected 1/0", out_valid, out_pc); end
        sb.delete();
        for (int k = 0; k < 5; k++) sb.push_back(64'(k));
        out_ready = 1'b1; #1;
        for (int c = 0; c < 30 && sb.size() != 0; c++) begin
            if (out_valid === 1'b1) begin
                exp = sb.pop_front();
                checks++; if (out_pc !== exp || out_instr !== ILEN'(exp)) begin errors++; $display("FAIL stall_seq: got pc=%h instr=%h expected pc=%h", out_pc, out_instr, exp); end
            end
            @(negedge clk); #1;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL stall_drain: %0d entries left expected 0", sb.size()); end
    endtask

    task automatic test_redirect;
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        #1;
        checks++; if (queue_count !== 3'd3) begin errors++; $display("FAIL redir_pre_count: got %0d expected 3", queue_count); end
        redirect_valid = 1'b1; redirect_pc = 64'h100; #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req: got %b expected 0", imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        checks++; if (queue_count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got count=%0d valid=%b expected 0/0", queue_count, out_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h100) begin errors++; $display("FAIL redir_addr: got valid=%b addr=%h expected 1/100", imem_req_valid, imem_addr); end
        sb.delete();
        for (int k = 0; k < 3; k++) sb.push_back(64'h100 + 64'(k));
        out_ready = 1'b1; #1;
        for (int c = 0; c < 30 && sb.size() != 0; c++) begin
            if (out_valid === 1'b1) begin
                exp = sb.pop_front();
                checks++; if (out_pc !== exp || out_instr !== ILEN'(exp)) begin errors++; $display("FAIL redir_seq: got pc=%h instr=%h expected pc=%h", out_pc, out_instr, exp); end
            end
            @(negedge clk); #1;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL redir_drain: %0d entries left expected 0", sb.size()); end
    endtask

    task automatic test_redirect_pop;
        do_reset(1'b0);
        repeat (10) @(negedge clk);
        #1;
        checks++; if (queue_count !== 3'd4) begin errors++; $display("FAIL rpop_full: got %0d expected 4", queue_count); end
        redirect_valid = 1'b1; redirect_pc = 64'h200; out_ready = 1'b1; #1;
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        checks++; if (queue_count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rpop_flush: got count=%0d valid=%b expected 0/0", queue_count, out_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h200) begin errors++; $display("FAIL rpop_addr: got valid=%b addr=%h expected 1/200", imem_req_valid, imem_addr); end
        sb.delete();
        sb.push_back(64'h200); sb.push_back(64'h201);
        for (int c = 0; c < 30 && sb.size() != 0; c++) begin
            if (out_valid === 1'b1) begin
                exp = sb.pop_front();
                checks++; if (out_pc !== exp || out_instr !== ILEN'(exp)) begin errors++; $display("FAIL rpop_seq: got pc=%h instr=%h expected pc=%h", out_pc, out_instr, exp); end
            end
            @(negedge clk); #1;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rpop_drain: %0d entries left expected 0", sb.size()); end
    endtask

    task automatic test_wrap;
        do_reset(1'b1);
        redirect_valid = 1'b1; redirect_pc = '1; #1;
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wrap_addr: got valid=%b addr=%h expected 1/ffffffffffffffff", imem_req_valid, imem_addr); end
        sb.delete();
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFF); sb.push_back(64'h0); sb.push_back(64'h1);
        for (int c = 0; c < 30 && sb.size() != 0; c++) begin
            if (out_valid === 1'b1) begin
                exp = sb.pop_front();
                checks++; if (out_pc !== exp || out_instr !== ILEN'(exp)) begin errors++; $display("FAIL wrap_seq: got pc=%h instr=%h expected pc=%h", out_pc, out_instr, exp); end
            end
            @(negedge clk); #1;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d entries left expected 0", sb.size()); end
    endtask

    task automatic test_mid_reset;
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (queue_count !== 3'd2) begin errors++; $display("FAIL mrst_pre_count: got %0d expected 2", queue_count); end
        rst = 1'b1; #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mrst_req: got %b expected 0", imem_req_valid); end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0 || queue_count !== 3'd0 || out_pc !== '0) begin errors++; $display("FAIL mrst_clear: got valid=%b count=%0d pc=%h expected 0/0/0", out_valid, queue_count, out_pc); end
        rst = 1'b0; #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'd0) begin errors++; $display("FAIL mrst_addr: got valid=%b addr=%h expected 1/0", imem_req_valid, imem_addr); end
        sb.delete();
        for (int k = 0; k < 3; k++) sb.push_back(64'(k));
        out_ready = 1'b1; #1;
        for (int c = 0; c < 30 && sb.size() != 0; c++) begin
            if (out_valid === 1'b1) begin
                exp = sb.pop_front();
                checks++; if (out_pc !== exp || out_instr !== ILEN'(exp)) begin errors++; $display("FAIL mrst_seq: got pc=%h instr=%h expected pc=%h", out_pc, out_instr, exp); end
            end
            @(negedge clk); #1;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL mrst_drain: %0d entries left expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_wrap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
